mem_hex_renderer: RTL and testbench

Downstream display stage between the shared 2048×32 main memory and the 160×120 `vga_adapter`. When granted the memory by the top-level arbiter through an enable/acknowledge handshake, it reads `NUM_WORDS` consecutive words and draws each as an 8-digit hexadecimal row using a 3×5 pixel font. Its `x`/`y`/`colour`/`plot` outputs feed the adapter directly.

---
 rtl/mem_hex_renderer.sv | 185 ++++++++++++++++++
 tb/tb_mem_hex_renderer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_hex_renderer.sv
// Reads NUM_WORDS consecutive memory words and draws each one as an 8-digit hex row
// (3x5 glyphs in 4x6 cells), one pixel per cycle, for a 160x120 VGA adapter.
module mem_hex_renderer #(
  parameter int unsigned NUM_WORDS   = 16,
  parameter logic [10:0] BASE_ADDR   = 11'd0,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned X0          = 0,
  parameter int unsigned Y0          = 0,
  parameter logic [2:0]  FG_COLOUR   = 3'b010,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        enable,
  output logic        acknowledge,
  output logic [10:0] mem_address,
  input  logic [31:0] mem_data,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot
);

  typedef enum logic [2:0] {StIdle, StFetch, StLatch, StDraw, StDone} state_e;

  localparam int unsigned WaitW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_LATENCY - 1);
  localparam logic [4:0]  LastWord = 5'(NUM_WORDS - 1);
  localparam logic [8:0]  XBase    = 9'(X0);
  localparam logic [7:0]  YBase    = 8'(Y0);

  state_e           r_state;
  logic [WaitW-1:0] r_wait;
  logic [4:0]       r_word_idx;
  logic [31:0]      r_word;
  logic [2:0]       r_digit;
  logic [2:0]       r_row;
  logic [1:0]       r_col;

  logic [3:0]  w_nibble;
  logic [14:0] w_glyph;
  logic [2:0]  w_font_row;
  logic        w_pixel_on;
  logic        w_draw;
  logic        w_in_range;
  logic [8:0]  w_x;
  logic [7:0]  w_y;
  logic [7:0]  w_row_base;

  // Five octal rows, top row in the most significant digit; bit 2 is the leftmost pixel.
  function automatic logic [14:0] font_glyph(input logic [3:0] v);
    logic [14:0] g;
    unique case (v)
      4'h0: g = 15'o75557;
      4'h1: g = 15'o26227;
      4'h2: g = 15'o71747;
      4'h3: g = 15'o71717;
      4'h4: g = 15'o55711;
      4'h5: g = 15'o74717;
      4'h6: g = 15'o74757;
      4'h7: g = 15'o71111;
      4'h8: g = 15'o75757;
      4'h9: g = 15'o75717;
      4'hA: g = 15'o25755;
      4'hB: g = 15'o65656;
      4'hC: g = 15'o74447;
      4'hD: g = 15'o65556;
      4'hE: g = 15'o74747;
      4'hF: g = 15'o74744;
    endcase
    return g;
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= StIdle;
      r_wait     <= '0;
      r_word_idx <= '0;
      r_word     <= '0;
      r_digit    <= '0;
      r_row      <= '0;
      r_col      <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (enable) begin
            r_word_idx <= '0;
            r_wait     <= '0;
            r_state    <= StFetch;
          end
        end
        StFetch: begin
          if (r_wait == WaitLast) r_state <= StLatch;
          else                    r_wait  <= r_wait + 1'b1;
        end
        StLatch: begin
          r_word  <= mem_data;
          r_digit <= '0;
          r_row   <= '0;
          r_col   <= '0;
          r_state <= StDraw;
        end
        StDraw: begin
          // Column wraps naturally from 3 to 0; row and digit advance on that wrap.
          r_col <= r_col + 1'b1;
          if (r_col == 2'd3) begin
            if (r_row == 3'd5) begin
              r_row   <= '0;
              r_digit <= r_digit + 1'b1;
              if (r_digit == 3'd7) begin
                if (r_word_idx == LastWord) begin
                  r_state <= StDone;
                end else begin
                  r_word_idx <= r_word_idx + 1'b1;
                  r_wait     <= '0;
                  r_state    <= StFetch;
                end
              end
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        StDone: begin
          if (!enable) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    w_nibble = r_word[31:28];
    unique case (r_digit)
      3'd0: w_nibble = r_word[31:28];
      3'd1: w_nibble = r_word[27:24];
      3'd2: w_nibble = r_word[23:20];
      3'd3: w_nibble = r_word[19:16];
      3'd4: w_nibble = r_word[15:12];
      3'd5: w_nibble = r_word[11:8];
      3'd6: w_nibble = r_word[7:4];
      3'd7: w_nibble = r_word[3:0];
    endcase
  end

  assign w_glyph = font_glyph(w_nibble);

  // Row 5 and column 3 are the inter-cell gaps and select no glyph bit.
  always_comb begin
    w_font_row = 3'b000;
    unique case (r_row)
      3'd0:    w_font_row = w_glyph[14:12];
      3'd1:    w_font_row = w_glyph[11:9];
      3'd2:    w_font_row = w_glyph[8:6];
      3'd3:    w_font_row = w_glyph[5:3];
      3'd4:    w_font_row = w_glyph[2:0];
      default: w_font_row = 3'b000;
    endcase
  end

  always_comb begin
    w_pixel_on = 1'b0;
    unique case (r_col)
      2'd0:    w_pixel_on = w_font_row[2];
      2'd1:    w_pixel_on = w_font_row[1];
      2'd2:    w_pixel_on = w_font_row[0];
      default: w_pixel_on = 1'b0;
    endcase
  end

  assign w_row_base = {3'b000, r_word_idx} * 8'd6;
  assign w_x        = XBase + {4'b0000, r_digit, 2'b00} + {7'b0000000, r_col};
  assign w_y        = YBase + w_row_base + {5'b00000, r_row};
  assign w_in_range = (w_x < 9'd160) && (w_y < 8'd120);
  assign w_draw     = (r_state == StDraw);

  assign acknowledge = (r_state == StDone);
  assign mem_address = BASE_ADDR + {6'b000000, r_word_idx};
  assign plot        = w_draw & w_in_range;
  assign x           = w_draw ? w_x[7:0] : 8'd0;
  assign y           = w_draw ? w_y[6:0] : 7'd0;
  assign colour      = !w_draw   ? 3'b000    :
                       w_pixel_on ? FG_COLOUR : BG_COLOUR;

endmodule

// File: tb/tb_mem_hex_renderer.sv
// Bench for mem_hex_renderer: two instances (default and clipped/slow-memory configurations)
// checked pixel by pixel against a cell/glyph model of the rendering rules.
module tb_mem_hex_renderer;

  localparam int         NW   [2] = '{16, 4};
  localparam int         LAT  [2] = '{2, 3};
  localparam int         XO   [2] = '{0, 140};
  localparam int         YO   [2] = '{0, 100};
  localparam logic [10:0] BASE [2] = '{11'd0, 11'd8};
  localparam logic [2:0] FG = 3'b010;
  localparam logic [2:0] BG = 3'b000;
  localparam int FONT [16] = '{'o75557, 'o26227, 'o71747, 'o71717, 'o55711, 'o74717,
                               'o74757, 'o71111, 'o75757, 'o75717, 'o25755, 'o65656,
                               'o74447, 'o65556, 'o74747, 'o74744};
  localparam int ONE_ROWS [5] = '{2, 6, 2, 2, 7};

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        en    [2];
  logic        ack   [2];
  logic [10:0] addr  [2];
  logic [31:0] mdata [2];
  logic [7:0]  px    [2];
  logic [6:0]  py    [2];
  logic [2:0]  pc    [2];
  logic        pp    [2];

  logic [31:0] mem [2048];
  logic [10:0] prev_addr [2];
  int          stab [2];
  logic [2:0]  cap [160][120];

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clock = ~clock;

  mem_hex_renderer dut0 (
    .clock(clock), .resetn(resetn), .enable(en[0]), .acknowledge(ack[0]),
    .mem_address(addr[0]), .mem_data(mdata[0]), .x(px[0]), .y(py[0]),
    .colour(pc[0]), .plot(pp[0])
  );

  mem_hex_renderer #(
    .NUM_WORDS(4), .BASE_ADDR(11'd8), .MEM_LATENCY(3), .X0(140), .Y0(100),
    .FG_COLOUR(3'b010), .BG_COLOUR(3'b000)
  ) dut1 (
    .clock(clock), .resetn(resetn), .enable(en[1]), .acknowledge(ack[1]),
    .mem_address(addr[1]), .mem_data(mdata[1]), .x(px[1]), .y(py[1]),
    .colour(pc[1]), .plot(pp[1])
  );

  // Memory returns X until the address has been stable for the configured latency.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      prev_addr[k] <= addr[k];
      stab[k] <= (addr[k] === prev_addr[k]) ? ((stab[k] < 1000) ? stab[k] + 1 : stab[k]) : 0;
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      mdata[k] = 'x;
      if (addr[k] === prev_addr[k] && stab[k] >= LAT[k] - 1) mdata[k] = mem[addr[k]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full run on instance k, checking every cycle from FETCH of word 0 to the first DONE cycle.
  task automatic run(input int k, input bit drop_en, output int plots);
    logic [31:0] word;
    logic [8:0]  x9;
    logic [7:0]  y8;
    logic        inr;
    logic [2:0]  ec;
    int          nib;
    int          on;
    plots = 0;
    en[k] = 1'b1;
    @(posedge clock); #1;
    if (drop_en) en[k] = 1'b0;
    for (int w = 0; w < NW[k]; w++) begin
      for (int i = 0; i <= LAT[k]; i++) begin
        chk($sformatf("fetch%0d_w%0d", k, w), 64'({ack[k], pp[k], addr[k]}),
            64'({1'b0, 1'b0, BASE[k] + 11'(w)}));
        @(posedge clock); #1;
      end
      word = mem[BASE[k] + 11'(w)];
      for (int d = 0; d < 8; d++) begin
        nib = int'((word >> (28 - 4 * d)) & 32'hF);
        for (int r = 0; r < 6; r++) begin
          for (int c = 0; c < 4; c++) begin
            on  = (r < 5 && c < 3) ? ((FONT[nib] >> (3 * (4 - r) + (2 - c))) & 1) : 0;
            ec  = (on != 0) ? FG : BG;
            x9  = 9'(XO[k] + 4 * d + c);
            y8  = 8'(YO[k] + 6 * w + r);
            inr = (x9 < 9'd160) && (y8 < 8'd120);
            chk($sformatf("pix%0d_w%0d_d%0d_r%0d_c%0d", k, w, d, r, c),
                64'({ack[k], pp[k], px[k], py[k], pc[k]}),
                64'({1'b0, inr, x9[7:0], y8[6:0], ec}));
            if (pp[k] === 1'b1) plots++;
            if (k == 0 && inr) cap[x9][y8] = pc[k];
            @(posedge clock); #1;
          end
        end
      end
    end
    chk($sformatf("ack_rise%0d", k), 64'(ack[k]), 64'(1));
  endtask

  initial begin
    en[0] = 1'b0;
    en[1] = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    #12;
    chk("reset0", 64'({ack[0], pp[0], px[0], py[0], pc[0], addr[0]}), 64'(0));
    chk("reset1_addr", 64'({ack[1], pp[1], addr[1]}), 64'({2'b00, 11'd8}));
    resetn = 1'b1;
    @(posedge clock); #1;

    // All-zero words: every cell is BG, every pixel in range.
    run(0, 1'b0, n);
    chk("plots_zero", 64'(n), 64'(3072));
    en[0] = 1'b0;
    @(posedge clock); #1;
    chk("ack_drop0", 64'(ack[0]), 64'(0));

    // Known word 0 plus random words; enable held through DONE.
    mem[0] = 32'h0123_89AF;
    for (int i = 1; i < 16; i++) mem[i] = $urandom;
    for (int i = 0; i < 160; i++) for (int j = 0; j < 120; j++) cap[i][j] = 3'b111;
    run(0, 1'b0, n);
    chk("pix_5_0", 64'(cap[5][0]), 64'(FG));
    chk("pix_4_0", 64'(cap[4][0]), 64'(BG));
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 3; c++)
        chk($sformatf("digit1_%0d_%0d", 4 + c, r), 64'(cap[4 + c][r]),
            64'((((ONE_ROWS[r] >> (2 - c)) & 1) != 0) ? FG : BG));
    for (int r = 0; r < 6; r++) chk($sformatf("gapcol_7_%0d", r), 64'(cap[7][r]), 64'(BG));
    for (int c = 0; c < 32; c++) chk($sformatf("gaprow_%0d_5", c), 64'(cap[c][5]), 64'(BG));
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      chk("hold_done", 64'({ack[0], pp[0], addr[0]}), 64'({1'b1, 1'b0, 11'd15}));
    end
    en[0] = 1'b0;
    @(posedge clock); #1;
    chk("ack_drop_hold", 64'(ack[0]), 64'(0));

    // Asynchronous reset in the middle of word 5's DRAW phase.
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    en[0] = 1'b1;
    @(posedge clock); #1;
    repeat (5 * 195 + 3 + 40) @(posedge clock);
    #1;
    chk("mid_draw", 64'({pp[0], addr[0]}), 64'({1'b1, 11'd5}));
    resetn = 1'b0;
    en[0]  = 1'b0;
    #1;
    chk("async_reset", 64'({ack[0], pp[0], addr[0]}), 64'(0));
    #2;
    resetn = 1'b1;
    @(posedge clock); #1;
    run(0, 1'b0, n);
    en[0] = 1'b0;
    @(posedge clock); #1;
    chk("ack_drop_restart", 64'(ack[0]), 64'(0));

    // Slow memory, clipped block, enable dropped right after the start.
    for (int i = 8; i < 12; i++) mem[i] = $urandom;
    run(1, 1'b1, n);
    @(posedge clock); #1;
    chk("ack_drop1", 64'(ack[1]), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
